// File: rtl/chip8_mem_responder.sv
// CHIP-8 4 KiB byte RAM behind a valid/ready request port; byte reads and 16-bit big-endian opcode fetches.
// Define CHIP8_FONT_INIT_EN to preload the 80-byte hex font at FONT_BASE after every reset.
//
// state | meaning
// INIT  | writing font byte font_idx (only with CHIP8_FONT_INIT_EN)
// IDLE  | req_ready=1; writes complete here, reads move on to RD0
// RD0   | first byte on rd_q; issue read of addr+1 for wide fetches
// RD1   | second byte on rd_q
// RESP  | rsp_valid=1, rsp_rdata held until rsp_ready
module chip8_mem_responder #(
  parameter logic [11:0] FONT_BASE = 12'h000,
  parameter int          MEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_wide,
  input  logic [11:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        init_done
);

  typedef enum logic [2:0] {INIT, IDLE, RD0, RD1, RESP} state_t;

  if (MEM_WORDS != 4096) begin : g_bad_depth
    $error("chip8_mem_responder: MEM_WORDS must be 4096 (12-bit address space)");
  end

  state_t      state;
  logic [7:0]  mem [0:MEM_WORDS-1];
  logic [7:0]  rd_q;
  logic [7:0]  hi_q;
  logic [11:0] addr_q;
  logic        wide_q;

  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;

`ifdef CHIP8_FONT_INIT_EN
  logic [6:0]  font_idx;

  function automatic logic [7:0] font_byte(input logic [6:0] idx);
    logic [39:0] glyph;
    logic [2:0]  row;
    row = 3'(idx % 7'd5);
    case (7'(idx / 7'd5))
      7'd0:    glyph = 40'hF0_90_90_90_F0;
      7'd1:    glyph = 40'h20_60_20_20_70;
      7'd2:    glyph = 40'hF0_10_F0_80_F0;
      7'd3:    glyph = 40'hF0_10_F0_10_F0;
      7'd4:    glyph = 40'h90_90_F0_10_10;
      7'd5:    glyph = 40'hF0_80_F0_10_F0;
      7'd6:    glyph = 40'hF0_80_F0_90_F0;
      7'd7:    glyph = 40'hF0_10_20_40_40;
      7'd8:    glyph = 40'hF0_90_F0_90_F0;
      7'd9:    glyph = 40'hF0_90_F0_10_F0;
      7'd10:   glyph = 40'hF0_90_F0_90_90;
      7'd11:   glyph = 40'hE0_90_E0_90_E0;
      7'd12:   glyph = 40'hF0_80_80_80_F0;
      7'd13:   glyph = 40'hE0_90_90_90_E0;
      7'd14:   glyph = 40'hF0_80_F0_80_F0;
      default: glyph = 40'hF0_80_F0_80_80;
    endcase
    case (row)
      3'd0:    font_byte = glyph[39:32];
      3'd1:    font_byte = glyph[31:24];
      3'd2:    font_byte = glyph[23:16];
      3'd3:    font_byte = glyph[15:8];
      default: font_byte = glyph[7:0];
    endcase
  endfunction
`endif

  // Single RAM port: the FSM state decides who owns the address this cycle.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = req_addr;
    mem_wdata = req_wdata;
    if (!rst) begin
      case (state)
`ifdef CHIP8_FONT_INIT_EN
        INIT: begin
          mem_we    = 1'b1;
          mem_addr  = FONT_BASE + {5'b0, font_idx};
          mem_wdata = font_byte(font_idx);
        end
`endif
        IDLE:    mem_we = req_valid & req_ready & req_write;
        RD0:     mem_addr = addr_q + 12'd1;
        default: mem_addr = req_addr;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else        rd_q <= mem[mem_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef CHIP8_FONT_INIT_EN
      state     <= INIT;
      init_done <= 1'b0;
      font_idx  <= 7'd0;
`else
      state     <= IDLE;
      init_done <= 1'b1;
`endif
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 16'h0000;
      addr_q    <= FONT_BASE;
      wide_q    <= 1'b0;
      hi_q      <= 8'h00;
    end else begin
      case (state)
`ifdef CHIP8_FONT_INIT_EN
        INIT: begin
          if (font_idx == 7'd79) begin
            state     <= IDLE;
            init_done <= 1'b1;
            req_ready <= 1'b1;
          end else begin
            font_idx <= font_idx + 7'd1;
          end
        end
`endif
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready && !req_write) begin
            state     <= RD0;
            req_ready <= 1'b0;
            addr_q    <= req_addr;
            wide_q    <= req_wide;
          end
        end
        RD0: begin
          if (wide_q) begin
            hi_q  <= rd_q;
            state <= RD1;
          end else begin
            rsp_rdata <= {8'h00, rd_q};
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RD1: begin
          rsp_rdata <= {hi_q, rd_q};
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_mem_responder.sv
// Directed bench for chip8_mem_responder; font preload checks run when CHIP8_FONT_INIT_EN is defined.
module tb_chip8_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_wide = 1'b0;
  logic [11:0] req_addr = 12'h000;
  logic [7:0]  req_wdata = 8'h00;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_rdata;
  logic        init_done;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef CHIP8_FONT_INIT_EN
  localparam logic EXP_DONE_RST = 1'b0;
  localparam int   EXP_INIT_CYC = 80;
`else
  localparam logic EXP_DONE_RST = 1'b1;
  localparam int   EXP_INIT_CYC = 1;
`endif

  chip8_mem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_wide  (req_wide),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, req_ready}, 32'd1);
  endtask

  // Counts negedges after rst drops until init_done, watching for stray ready/response.
  task automatic wait_init(input string tag);
    int  n = 0;
    logic early_rdy = 1'b0;
    logic stray_rsp = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (req_ready && !init_done) early_rdy = 1'b1;
      if (rsp_valid) stray_rsp = 1'b1;
    end while (init_done !== 1'b1 && n < 200);
    check({tag, "_cycles"}, n, EXP_INIT_CYC);
    check({tag, "_early_rdy"}, {31'd0, early_rdy}, 32'd0);
    check({tag, "_stray_rsp"}, {31'd0, stray_rsp}, 32'd0);
    check({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic do_write(input logic [11:0] a, input logic [7:0] d, input logic w);
    wait_ready("wr_rdy");
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; req_wide = w;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; req_wide = 1'b0;
    check("wr_stays_idle", {31'd0, req_ready}, 32'd1);
    check("wr_no_rsp", {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic do_read(input logic [11:0] a, input logic w, input int hold, input logic early,
                         input int exp_lat, input logic [15:0] exp);
    int lat;
    wait_ready("rd_rdy");
    req_valid = 1'b1; req_write = 1'b0; req_wide = w; req_addr = a; req_wdata = 8'hFF;
    rsp_ready = early;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_wide = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("rd_latency", lat, exp_lat);
    check("rd_data", {16'd0, rsp_rdata}, {16'd0, exp});
    // While stalled, hammer the request port with a write that must be ignored.
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = 8'hEE;
      @(negedge clk);
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_data", {16'd0, rsp_rdata}, {16'd0, exp});
      check("hold_no_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0; req_write = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("hs_valid_low", {31'd0, rsp_valid}, 32'd0);
    check("hs_idle", {31'd0, req_ready}, 32'd1);
    check("hs_data_held", {16'd0, rsp_rdata}, {16'd0, exp});
  endtask

  task automatic reset_in_rd1();
    logic seen = 1'b0;
    int   n = 0;
    wait_ready("abort_rdy");
    req_valid = 1'b1; req_write = 1'b0; req_wide = 1'b1; req_addr = 12'h200;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_wide = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort_ready", {31'd0, req_ready}, 32'd0);
    check("abort_rdata", {16'd0, rsp_rdata}, 32'd0);
    check("abort_init_done", {31'd0, init_done}, {31'd0, EXP_DONE_RST});
    rst = 1'b0;
    wait_init("reinit");
    repeat (5) begin
      @(negedge clk);
      n++;
      if (rsp_valid) seen = 1'b1;
    end
    check("abort_lost_rsp", {31'd0, seen}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, {31'd0, EXP_DONE_RST});
    rst = 1'b0;
    wait_init("init");

`ifdef CHIP8_FONT_INIT_EN
    do_read(12'h000, 1'b0, 0, 1'b0, 2, 16'h00F0);
    do_read(12'h000, 1'b1, 0, 1'b0, 3, 16'hF090);
    do_read(12'h04B, 1'b1, 0, 1'b0, 3, 16'hF080);
`endif

    do_write(12'h300, 8'h55, 1'b0);
    do_read(12'h300, 1'b0, 0, 1'b0, 2, 16'h0055);

    do_write(12'hFFF, 8'hA2, 1'b0);
    do_write(12'h000, 8'h1E, 1'b0);
    do_read(12'hFFF, 1'b1, 0, 1'b0, 3, 16'hA21E);

    do_write(12'h200, 8'h12, 1'b0);
    do_write(12'h201, 8'h34, 1'b0);
    do_read(12'h200, 1'b1, 5, 1'b0, 3, 16'h1234);
    do_read(12'h201, 1'b0, 0, 1'b1, 2, 16'h0034);

    do_write(12'h300, 8'h7C, 1'b1);
    do_write(12'h301, 8'h9A, 1'b0);
    do_read(12'h300, 1'b1, 0, 1'b1, 3, 16'h7C9A);
    repeat (3) @(negedge clk);
    check("idle_rdata_hold", {16'd0, rsp_rdata}, 32'h7C9A);
    check("idle_no_rsp", {31'd0, rsp_valid}, 32'd0);

    reset_in_rd1();
    do_read(12'h201, 1'b0, 0, 1'b0, 2, 16'h0034);
    do_read(12'h300, 1'b0, 0, 1'b0, 2, 16'h007C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
